imsic_msi_arbiter: RTL and testbench
====================================

// Module: imsic_msi_arbiter
// PURPOSE
//  Shares the single MSI delivery channel (i_msi_info / i_msi_info_vld) of imsic_csr_gate between
//  NR_REQ MSI sources (bus slave ports, test injectors). Round-robin arbitration; one MSI per
//  delivery frame. Each frame holds vld high, then low, with info stable throughout. The gate
//  synchronises vld and samples info on the synchronised falling edge, so info stays stable across that sync.
// PARAMETERS
//  NR_REQ          2    number of requesters (>=1)
//  MSI_INFO_WIDTH  17   {hart_id, intp_file, setipnum} word width, matches imsic_csr_gate
//  VLD_HIGH_CYC    4    cycles o_msi_info_vld is held high per frame (>=1)
//  VLD_GAP_CYC     6    cycles vld held low, info frozen, after high phase (>= EID_VLD_DLY+4)
// PORTS
//  clk             in   1                      clock
//  rstn            in   1                      async active-low reset
//  req_vld         in   NR_REQ                 requester i has an MSI pending
//  req_info        in   NR_REQ*MSI_INFO_WIDTH  slice i = MSI word of requester i
//  req_rdy         out  NR_REQ                 one-hot accept pulse, 1 cycle
//  o_msi_info      out  MSI_INFO_WIDTH         to imsic_csr_gate i_msi_info
//  o_msi_info_vld  out  1                      to imsic_csr_gate i_msi_info_vld
//  o_busy          out  1                      frame in progress (state != IDLE)
//  o_grant_id      out  $clog2(NR_REQ) (min 1) index of last granted requester
// BEHAVIOUR
//  Reset: req_rdy=0, o_msi_info=0, o_msi_info_vld=0, o_busy=0, o_grant_id=0, rr pointer=0, state=IDLE.
//  FSM IDLE -> HIGH -> GAP -> IDLE; cycle counter cnt, width $clog2(max(HIGH,GAP)+1).
//  IDLE: if |req_vld, grant = first i with req_vld[i] searching from ptr upward, wrapping mod NR_REQ.
//   Same cycle: req_rdy[grant]=1 (comb, from registered ptr), accept happens on req_vld&req_rdy.
//   Next edge: o_msi_info<=req_info[grant], o_msi_info_vld<=1, o_grant_id<=grant,
//   ptr<=grant+1 (wrap to 0 at NR_REQ), cnt<=0, state<=HIGH.
//  HIGH: vld=1; when cnt==VLD_HIGH_CYC-1 -> vld<=0, cnt<=0, state<=GAP; else cnt++.
//  GAP: vld=0, info frozen; when cnt==VLD_GAP_CYC-1 -> state<=IDLE; else cnt++.
//  o_msi_info changes only on IDLE->HIGH edge; never in HIGH or GAP.
//  req_rdy is 0 outside IDLE; at most one bit set; frame period = 1+VLD_HIGH_CYC+VLD_GAP_CYC.
//  Requester may drop req_vld before grant with no effect; must hold req_info stable while req_vld=1.
//  NR_REQ==1: ptr fixed 0, grant whenever req_vld[0] in IDLE.
//  No content filtering: setipnum==0 or out-of-range words are forwarded unchanged (gate discards).
//  Reset mid-frame: vld drops to 0 asynchronously, frame lost, no req_rdy retried.
// CONFIGURATION
//  IMSIC_MSI_ARB_STAT_EN defined: adds output o_msi_cnt [31:0], reset 0, +1 on each
//   IDLE->HIGH transition, wraps 0xFFFF_FFFF->0; plus o_collide [1:0]: sticky bit0 set when
//   >=2 req_vld bits high in a granting IDLE cycle; cleared only by reset.
//  Not defined: ports absent, no counter logic.
// TESTING
//  Single req: NR_REQ=2, req_vld=01, info=0x0_0045 -> rdy=01 one cycle; vld high 4 cyc; low 6 cyc; info 0x45 held 10.
//  Contention: req_vld=11 held, info0=0x1,info1=0x2 -> grants 0,1,0,1; o_msi_info 0x1,0x2,0x1; period 11 cyc.
//  Back-to-back same requester: req_vld=01 continuous -> next rdy exactly 11 cycles after previous.
//  Reset mid-HIGH: rstn=0 at cnt=2 -> vld=0, busy=0 immediately; after release ptr=0, req1 pending granted first only if req0 idle.
//  End-to-end with imsic_csr_gate (EID_VLD_DLY=0): info {hart=0,file=1,num=5} -> gate eip_final[S file reg][5]=1.
//  STAT_EN: 3 frames -> o_msi_cnt=3; simultaneous req_vld=11 -> o_collide[0]=1.

Source files
------------

// File: rtl/imsic_msi_arbiter.sv
// Round-robin arbiter that multiplexes NR_REQ MSI sources onto the single imsic_csr_gate delivery channel.
// Optional statistics ports are enabled with `define IMSIC_MSI_ARB_STAT_EN.
module imsic_msi_arbiter #(
  parameter int NR_REQ         = 2,
  parameter int MSI_INFO_WIDTH = 17,
  parameter int VLD_HIGH_CYC   = 4,
  parameter int VLD_GAP_CYC    = 6,
  localparam int ID_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1,
  localparam int MAXC  = (VLD_HIGH_CYC > VLD_GAP_CYC) ? VLD_HIGH_CYC : VLD_GAP_CYC,
  localparam int CNT_W = $clog2(MAXC + 1)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NR_REQ-1:0]                req_vld,
  input  logic [NR_REQ*MSI_INFO_WIDTH-1:0] req_info,
  output logic [NR_REQ-1:0]                req_rdy,
  output logic [MSI_INFO_WIDTH-1:0]        o_msi_info,
  output logic                             o_msi_info_vld,
  output logic                             o_busy,
  output logic [ID_W-1:0]                  o_grant_id
`ifdef IMSIC_MSI_ARB_STAT_EN
  ,
  output logic [31:0]                      o_msi_cnt,
  output logic [1:0]                       o_collide
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP} state_t;

  state_t             r_state, w_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_grant;
  logic               w_found;
  logic               w_start;
  logic               w_high_end;
  logic               w_gap_end;
  int                 w_idx;

  // Scan from the pointer downward in priority so the closest-to-ptr request is the last (winning) write.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int k = NR_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_ptr) + k) % NR_REQ;
      if (req_vld[w_idx]) begin
        w_found = 1'b1;
        w_grant = ID_W'(w_idx);
      end
    end
  end

  assign w_start    = (r_state == S_IDLE) && w_found;
  assign w_high_end = (r_cnt == CNT_W'(VLD_HIGH_CYC - 1));
  assign w_gap_end  = (r_cnt == CNT_W'(VLD_GAP_CYC - 1));

  always_comb begin
    req_rdy = '0;
    if (w_start) req_rdy[w_grant] = 1'b1;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found)    w_nxt = S_HIGH;
      S_HIGH:  if (w_high_end) w_nxt = S_GAP;
      S_GAP:   if (w_gap_end)  w_nxt = S_IDLE;
      default:                 w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt          <= '0;
      r_ptr          <= '0;
      o_msi_info     <= '0;
      o_msi_info_vld <= 1'b0;
      o_grant_id     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          o_msi_info     <= req_info[w_grant*MSI_INFO_WIDTH +: MSI_INFO_WIDTH];
          o_msi_info_vld <= 1'b1;
          o_grant_id     <= w_grant;
          r_ptr          <= (int'(w_grant) == NR_REQ - 1) ? '0 : w_grant + 1'b1;
          r_cnt          <= '0;
        end
        S_HIGH: begin
          if (w_high_end) begin
            o_msi_info_vld <= 1'b0;
            r_cnt          <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: if (!w_gap_end) r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);

`ifdef IMSIC_MSI_ARB_STAT_EN
  logic r_coll;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_msi_cnt <= '0;
      r_coll    <= 1'b0;
    end else if (w_start) begin
      o_msi_cnt <= o_msi_cnt + 32'd1;
      if ($countones(req_vld) > 1) r_coll <= 1'b1;
    end
  end

  assign o_collide = {1'b0, r_coll};
`endif

endmodule

// File: tb/tb_imsic_msi_arbiter.sv
// Bench for imsic_msi_arbiter: directed scenarios plus random traffic against a frame-position reference model.
module tb_imsic_msi_arbiter;
  localparam int NR = 2;
  localparam int W  = 17;
  localparam int H  = 4;
  localparam int G  = 6;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NR-1:0]   req_vld;
  logic [NR*W-1:0] req_info;
  logic [NR-1:0]   req_rdy;
  logic [W-1:0]    o_msi_info;
  logic            o_msi_info_vld;
  logic            o_busy;
  logic [0:0]      o_grant_id;
`ifdef IMSIC_MSI_ARB_STAT_EN
  logic [31:0]     o_msi_cnt;
  logic [1:0]      o_collide;
`endif

  imsic_msi_arbiter #(.NR_REQ(NR), .MSI_INFO_WIDTH(W), .VLD_HIGH_CYC(H), .VLD_GAP_CYC(G)) dut (
    .clk(clk), .rstn(rstn), .req_vld(req_vld), .req_info(req_info), .req_rdy(req_rdy),
    .o_msi_info(o_msi_info), .o_msi_info_vld(o_msi_info_vld), .o_busy(o_busy), .o_grant_id(o_grant_id)
`ifdef IMSIC_MSI_ARB_STAT_EN
    , .o_msi_cnt(o_msi_cnt), .o_collide(o_collide)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: frame position (0 = idle, 1..H+G = cycle within frame) and rr pointer.
  int          m_ptr, m_pos, m_gid, cyc, last_g;
  logic [W-1:0] m_info;
  int unsigned m_cnt;
  bit          m_coll;
  int          gq[$];
  int          gt[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_pos = 0; m_gid = 0; m_info = '0; m_cnt = 0; m_coll = 0; last_g = -1;
  endtask

  // Called just after a negedge with inputs driven; returns at the following negedge.
  task automatic cycle();
    int g;
    logic [NR-1:0] er;
    #1;
    g = -1;
    if (m_pos == 0)
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (g < 0 && req_vld[i]) g = i;
      end
    er = (g >= 0) ? NR'(1 << g) : '0;
    chk("req_rdy", 64'(req_rdy), 64'(er));
    chk("busy", 64'(o_busy), 64'(m_pos != 0));
    chk("vld", 64'(o_msi_info_vld), 64'(m_pos >= 1 && m_pos <= H));
    chk("info", 64'(o_msi_info), 64'(m_info));
    chk("grant_id", 64'(o_grant_id), 64'(m_gid));
`ifdef IMSIC_MSI_ARB_STAT_EN
    chk("msi_cnt", 64'(o_msi_cnt), 64'(m_cnt));
    chk("collide", 64'(o_collide), 64'(m_coll));
`endif
    last_g = g;
    @(posedge clk);
    cyc++;
    if (g >= 0) begin
      m_info = req_info[g*W +: W];
      m_gid  = g;
      m_ptr  = (g + 1) % NR;
      m_pos  = 1;
      m_cnt++;
      if ($countones(req_vld) > 1) m_coll = 1;
      gq.push_back(g);
      gt.push_back(cyc);
    end else if (m_pos > 0) begin
      m_pos = (m_pos == H + G) ? 0 : m_pos + 1;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int budget;
    rstn = 1'b0; req_vld = '0; req_info = '0; cyc = 0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_vld", 64'(o_msi_info_vld), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_info", 64'(o_msi_info), 64'd0);
    chk("rst_rdy", 64'(req_rdy), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Single request, zero-width-ish word forwarded unchanged
    req_info = {17'h0, 17'h0_0045}; req_vld = 2'b01;
    cycle();
    chk("single_gid", 64'(gq.size()), 64'd1);
    req_vld = 2'b00;
    run(H + G + 2);
    chk("single_info_held", 64'(o_msi_info), 64'h45);

    // Contention: alternating grants
    gq.delete(); gt.delete();
    req_info = {17'h2, 17'h1}; req_vld = 2'b11;
    run(4 * (1 + H + G));
    req_vld = 2'b00;
    chk("cont_n", 64'(gq.size()), 64'd4);
    if (gq.size() == 4) begin
      chk("cont_g0", 64'(gq[0]), 64'd1);
      chk("cont_g1", 64'(gq[1]), 64'd0);
      chk("cont_g2", 64'(gq[2]), 64'd1);
      chk("cont_g3", 64'(gq[3]), 64'd0);
      chk("cont_period", 64'(gt[2] - gt[1]), 64'(1 + H + G));
    end
    run(H + G + 1);

    // Back-to-back same requester
    gq.delete(); gt.delete();
    req_info = {17'h0, 17'h1_ABCD}; req_vld = 2'b01;
    run(3 * (1 + H + G));
    req_vld = 2'b00;
    chk("b2b_n", 64'(gq.size()), 64'd3);
    if (gq.size() == 3) chk("b2b_period", 64'(gt[2] - gt[1]), 64'(1 + H + G));
    run(H + G + 1);

    // Reset in the middle of the high phase (cnt == 2 -> frame position 3)
    req_info = {17'h0_0033, 17'h0_0077}; req_vld = 2'b10;
    budget = 50;
    while (m_pos != 3 && budget > 0) begin cycle(); budget--; end
    chk("midrst_reach", 64'(m_pos), 64'd3);
    rstn = 1'b0; req_vld = 2'b00;
    #1;
    chk("midrst_vld", 64'(o_msi_info_vld), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    gq.delete();
    req_vld = 2'b11;
    cycle();
    chk("postrst_first", 64'(gq.size() > 0 ? gq[0] : 9), 64'd0);
    req_vld = 2'b00;
    run(H + G + 1);
    req_vld = 2'b10;
    cycle();
    chk("postrst_req1", 64'(o_grant_id), 64'd1);
    req_vld = 2'b00;
    run(H + G + 1);

    // Random traffic, info stable while pending
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (req_vld[i] && last_g == i) begin
          if ($urandom_range(1, 0) == 1) req_info[i*W +: W] = W'($urandom);
          else req_vld[i] = 1'b0;
        end else if (req_vld[i]) begin
          if ($urandom_range(9, 0) == 0) req_vld[i] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          req_info[i*W +: W] = W'($urandom);
          req_vld[i] = 1'b1;
        end
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
